// File: rtl/wb_arb_pkg.sv
// Shared types and sizes for the four-port Wishbone round-robin arbiter.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        OWN,
        DRAIN
    } arb_state_t;

    localparam int NPORTS  = 4;
    localparam int GRANT_W = 2;
    localparam int CNT_W   = 4;
    localparam int WDOG_W  = 16;
    localparam int ADR_W   = 32;
    localparam int DAT_W   = 32;
    localparam int SEL_W   = DAT_W / 8;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester after the pointer, wrapping mod NPORTS.
module rr_picker
    import wb_arb_pkg::*;
(
    input  logic [NPORTS-1:0]  req_i,
    input  logic [GRANT_W-1:0] ptr_i,
    output logic               vld_o,
    output logic [GRANT_W-1:0] pick_o
);

    logic [GRANT_W-1:0] idx;

    always_comb begin
        vld_o  = 1'b0;
        pick_o = ptr_i;
        idx    = ptr_i;
        // Walk from the farthest offset to the nearest so the nearest requester wins.
        for (int i = NPORTS; i >= 1; i--) begin
            idx = ptr_i + GRANT_W'(i);
            if (req_i[idx]) begin
                vld_o  = 1'b1;
                pick_o = idx;
            end
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Four-port round-robin Wishbone arbiter: whole-cycle grants, a cap on outstanding
// pipelined transfers, a drain phase before handoff and an ack watchdog.
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int MAXOUT  = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NPORTS-1:0]         in_cyc_i,
    input  logic [NPORTS-1:0]         in_stb_i,
    input  logic [NPORTS-1:0]         in_we_i,
    input  logic [NPORTS*SEL_W-1:0]   in_sel_i,
    input  logic [NPORTS*ADR_W-1:0]   in_adr_i,
    input  logic [NPORTS*DAT_W-1:0]   in_dat_i,
    output logic [NPORTS-1:0]         in_stall_o,
    output logic [NPORTS-1:0]         in_ack_o,
    output logic [NPORTS*DAT_W-1:0]   in_dat_o,
    output logic                      out_cyc_o,
    output logic                      out_stb_o,
    output logic                      out_we_o,
    output logic [SEL_W-1:0]          out_sel_o,
    output logic [ADR_W-1:0]          out_adr_o,
    output logic [DAT_W-1:0]          out_dat_o,
    input  logic                      out_stall_i,
    input  logic                      out_ack_i,
    input  logic [DAT_W-1:0]          out_dat_i,
    output logic [GRANT_W-1:0]        grant_o,
    output logic                      busy_o,
    output logic                      timeout_o
);

    localparam logic [CNT_W-1:0]  MAXOUT_C  = CNT_W'(MAXOUT);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

    arb_state_t          state_q, state_d;
    logic [GRANT_W-1:0]  grant_q, grant_d;
    logic [GRANT_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_upd;
    logic [WDOG_W-1:0]   wdog_q, wdog_d;
    logic                timeout_q, timeout_d;

    logic                pick_vld;
    logic [GRANT_W-1:0]  pick;
    logic                full;
    logic                xfer_inc;
    logic                xfer_dec;
    logic                wdog_run;
    logic                expire;

    rr_picker u_picker (
        .req_i  (in_cyc_i),
        .ptr_i  (ptr_q),
        .vld_o  (pick_vld),
        .pick_o (pick)
    );

    assign full = (cnt_q == MAXOUT_C);

    always_comb begin
        out_cyc_o  = 1'b0;
        out_stb_o  = 1'b0;
        out_we_o   = 1'b0;
        out_sel_o  = '0;
        out_adr_o  = '0;
        out_dat_o  = '0;
        in_stall_o = '1;
        in_ack_o   = '0;
        in_dat_o   = '0;
        case (state_q)
            OWN: begin
                out_cyc_o  = in_cyc_i[grant_q];
                out_stb_o  = in_stb_i[grant_q] & ~full;
                out_we_o   = in_we_i[grant_q];
                out_sel_o  = in_sel_i[grant_q*SEL_W +: SEL_W];
                out_adr_o  = in_adr_i[grant_q*ADR_W +: ADR_W];
                out_dat_o  = in_dat_i[grant_q*DAT_W +: DAT_W];
                in_stall_o[grant_q]              = out_stall_i | full;
                in_ack_o[grant_q]                = out_ack_i;
                in_dat_o[grant_q*DAT_W +: DAT_W] = out_dat_i;
            end
            // Keep the slave's cycle open while late acks are swallowed.
            DRAIN: out_cyc_o = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        xfer_inc = out_stb_o & ~out_stall_i;
        xfer_dec = out_ack_i & (cnt_q != '0);
        cnt_upd  = cnt_q;
        if (xfer_inc && !xfer_dec) begin
            cnt_upd = cnt_q + 1'b1;
        end else if (!xfer_inc && xfer_dec) begin
            cnt_upd = cnt_q - 1'b1;
        end
        wdog_run = (state_q != IDLE) && (cnt_q != '0) && !out_ack_i;
        expire   = wdog_run && (wdog_q == WDOG_LAST);
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_upd;
        wdog_d    = wdog_run ? (wdog_q + 1'b1) : '0;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant_d = pick;
                    state_d = OWN;
                end
            end
            OWN: begin
                if (!in_cyc_i[grant_q]) begin
                    ptr_d   = grant_q;
                    state_d = (cnt_upd == '0) ? IDLE : DRAIN;
                end
            end
            DRAIN: begin
                if (cnt_upd == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A stuck slave abandons its transfers; the owner must re-arbitrate.
        if (expire) begin
            state_d   = IDLE;
            cnt_d     = '0;
            wdog_d    = '0;
            ptr_d     = grant_q;
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            ptr_q     <= GRANT_W'(NPORTS - 1);
            cnt_q     <= '0;
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant_o   = grant_q;
    assign busy_o    = (state_q != IDLE);
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter: arbitration vector table plus hand-written multi-cycle
// sequences, with address/ack scoreboards drained by a negedge monitor.
module tb_wb_rr_arbiter;

    localparam int MAXOUT  = 4;
    localparam int TIMEOUT = 16;

    typedef struct {
        logic [3:0] req;
        logic [1:0] gnt;
    } arb_vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   in_cyc = '0, in_stb = '0, in_we = '0;
    logic [15:0]  in_sel = '0;
    logic [127:0] in_adr = '0, in_dat_m = '0;
    logic [3:0]   in_stall, in_ack;
    logic [127:0] in_dat_s;
    logic         out_cyc, out_stb, out_we;
    logic [3:0]   out_sel;
    logic [31:0]  out_adr, out_dat_m;
    logic         out_stall = 1'b0, out_ack = 1'b0;
    logic [31:0]  out_dat_s = '0;
    logic [1:0]   grant;
    logic         busy, tmo;

    int           checks = 0;
    int           errors = 0;
    int           n_acc  = 0;
    logic [31:0]  adr_q[$];
    logic [33:0]  ack_q[$];

    arb_vec_t     vec[10];
    int           exp_g[5];
    int           due[$];
    int           issued, acked, mout, g;
    logic         ack_now, exp_full, acc, seen;
    logic [33:0]  e;

    wb_rr_arbiter #(.MAXOUT(MAXOUT), .TIMEOUT(TIMEOUT)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_cyc_i    (in_cyc),
        .in_stb_i    (in_stb),
        .in_we_i     (in_we),
        .in_sel_i    (in_sel),
        .in_adr_i    (in_adr),
        .in_dat_i    (in_dat_m),
        .in_stall_o  (in_stall),
        .in_ack_o    (in_ack),
        .in_dat_o    (in_dat_s),
        .out_cyc_o   (out_cyc),
        .out_stb_o   (out_stb),
        .out_we_o    (out_we),
        .out_sel_o   (out_sel),
        .out_adr_o   (out_adr),
        .out_dat_o   (out_dat_m),
        .out_stall_i (out_stall),
        .out_ack_i   (out_ack),
        .out_dat_i   (out_dat_s),
        .grant_o     (grant),
        .busy_o      (busy),
        .timeout_o   (tmo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_cyc = '0;
        in_stb = '0;
        out_ack = 1'b0;
        out_stall = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    // Scoreboard monitor: accepted strobes and forwarded acks.
    always @(negedge clk) begin
        if (out_cyc && out_stb && !out_stall) begin
            n_acc++;
            if (adr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL stb_unexp: accepted adr 0x%0h, none expected", out_adr);
            end else begin
                chk("stb_adr", out_adr, adr_q.pop_front());
            end
        end
        for (int p = 0; p < 4; p++) begin
            if (in_ack[p]) begin
                if (ack_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ack_unexp: port %0d acked dat 0x%0h, none expected", p, in_dat_s[p*32 +: 32]);
                end else begin
                    e = ack_q.pop_front();
                    chk("ack_port", 32'(p), {30'd0, e[33:32]});
                    chk("ack_dat", in_dat_s[p*32 +: 32], e[31:0]);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at 500000, limit reached");
        $fatal(1, "bench timeout");
    end

    initial begin
        vec[0] = '{4'b0100, 2'd2};
        vec[1] = '{4'b1111, 2'd3};
        vec[2] = '{4'b1111, 2'd0};
        vec[3] = '{4'b0101, 2'd2};
        vec[4] = '{4'b0101, 2'd0};
        vec[5] = '{4'b1010, 2'd1};
        vec[6] = '{4'b1001, 2'd3};
        vec[7] = '{4'b0011, 2'd0};
        vec[8] = '{4'b0010, 2'd1};
        vec[9] = '{4'b0100, 2'd2};
        exp_g  = '{0, 1, 2, 3, 0};

        // Reset state
        do_reset();
        #1;
        chk("rst_grant", {30'd0, grant}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_tmo", {31'd0, tmo}, 0);
        chk("rst_cyc", {31'd0, out_cyc}, 0);
        chk("rst_stall", {28'd0, in_stall}, 32'hF);
        chk("rst_ack", {28'd0, in_ack}, 0);

        // Single read on port 2
        in_cyc[2] = 1'b1;
        in_stb[2] = 1'b1;
        in_sel[8 +: 4] = 4'hF;
        in_adr[64 +: 32] = 32'h100;
        in_dat_m[64 +: 32] = 32'h1234_5678;
        adr_q.push_back(32'h100);
        #1;
        chk("a_lat0_cyc", {31'd0, out_cyc}, 0);
        tick();
        out_stall = 1'b1;
        #1;
        chk("a_cyc", {31'd0, out_cyc}, 1);
        chk("a_grant", {30'd0, grant}, 2);
        chk("a_sel", {28'd0, out_sel}, 32'hF);
        chk("a_we", {31'd0, out_we}, 0);
        chk("a_datm", out_dat_m, 32'h1234_5678);
        chk("a_stall_fwd", {31'd0, in_stall[2]}, 1);
        tick();
        out_stall = 1'b0;
        #1;
        chk("a_stall_rel", {31'd0, in_stall[2]}, 0);
        tick();
        in_stb[2] = 1'b0;
        tick();
        out_ack = 1'b1;
        out_dat_s = 32'hDEAD_BEEF;
        ack_q.push_back({2'd2, 32'hDEAD_BEEF});
        tick();
        out_ack = 1'b0;
        in_cyc[2] = 1'b0;
        #1;
        chk("a_drop_cyc", {31'd0, out_cyc}, 0);
        tick();
        #1;
        chk("a_idle_busy", {31'd0, busy}, 0);
        chk("a_grant_hold", {30'd0, grant}, 2);

        // Arbitration order table
        for (int i = 0; i < 10; i++) begin
            in_cyc = vec[i].req;
            #1;
            chk("t_idle_cyc", {31'd0, out_cyc}, 0);
            chk("t_idle_stall", {28'd0, in_stall}, 32'hF);
            tick();
            #1;
            chk("t_grant", {30'd0, grant}, {30'd0, vec[i].gnt});
            chk("t_busy", {31'd0, busy}, 1);
            chk("t_own_cyc", {31'd0, out_cyc}, 1);
            chk("t_own_stall", {28'd0, in_stall}, {28'd0, 4'hF & ~(4'b0001 << vec[i].gnt)});
            in_cyc = '0;
            #1;
            chk("t_drop_cyc", {31'd0, out_cyc}, 0);
            tick();
            #1;
            chk("t_idle_busy", {31'd0, busy}, 0);
        end

        // Four masters, one transfer each
        do_reset();
        in_cyc = 4'hF;
        for (int r = 0; r < 5; r++) begin
            for (int w = 0; w < 8 && !busy; w++) tick();
            chk("b_busy", {31'd0, busy}, 1);
            g = exp_g[r];
            chk("b_grant", {30'd0, grant}, 32'(g));
            in_stb[g] = 1'b1;
            in_adr[g*32 +: 32] = 32'h200 + 32'(r * 4);
            adr_q.push_back(32'h200 + 32'(r * 4));
            #1;
            chk("b_cyc", {31'd0, out_cyc}, 1);
            tick();
            in_stb[g] = 1'b0;
            out_ack = 1'b1;
            out_dat_s = 32'h1000 + 32'(r);
            ack_q.push_back({2'(g), 32'h1000 + 32'(r)});
            tick();
            out_ack = 1'b0;
            in_cyc[g] = 1'b0;
            #1;
            chk("b_drop_cyc", {31'd0, out_cyc}, 0);
            tick();
            if (r == 0) in_cyc[0] = 1'b1;
            #1;
            chk("b_gap_cyc", {31'd0, out_cyc}, 0);
            chk("b_gap_busy", {31'd0, busy}, 0);
        end

        // Outstanding cap on port 1
        n_acc = 0;
        in_cyc[1] = 1'b1;
        tick();
        issued = 0;
        acked = 0;
        mout = 0;
        due.delete();
        for (int c = 0; c < 40 && !(issued == 6 && acked == 6); c++) begin
            in_stb[1] = (issued < 6);
            in_adr[32 +: 32] = 32'h300 + 32'(issued * 4);
            ack_now = (due.size() > 0) && (due[0] == c);
            out_ack = ack_now;
            if (ack_now) begin
                void'(due.pop_front());
                out_dat_s = 32'hA000 + 32'(acked);
                ack_q.push_back({2'd1, 32'hA000 + 32'(acked)});
                acked++;
            end
            #1;
            exp_full = (mout == MAXOUT);
            chk("c_stall", {31'd0, in_stall[1]}, {31'd0, exp_full});
            if (ack_now && acked == 1) chk("c_acc_before_ack", 32'(n_acc), 4);
            acc = in_stb[1] && !exp_full;
            if (acc) begin
                adr_q.push_back(32'h300 + 32'(issued * 4));
                due.push_back(c + 8);
                issued++;
            end
            mout = mout + int'(acc) - int'(ack_now);
            tick();
        end
        out_ack = 1'b0;
        in_stb[1] = 1'b0;
        in_cyc[1] = 1'b0;
        chk("c_total_acc", 32'(n_acc), 6);
        tick();
        tick();

        // Drain after early cyc drop on port 3, port 0 waiting
        in_cyc = 4'b1001;
        tick();
        #1;
        chk("d_grant", {30'd0, grant}, 3);
        for (int k = 0; k < 3; k++) begin
            in_stb[3] = 1'b1;
            in_adr[96 +: 32] = 32'h400 + 32'(k * 4);
            adr_q.push_back(32'h400 + 32'(k * 4));
            tick();
        end
        in_stb[3] = 1'b0;
        in_cyc[3] = 1'b0;
        tick();
        #1;
        chk("d_busy", {31'd0, busy}, 1);
        chk("d_cyc", {31'd0, out_cyc}, 1);
        chk("d_stb", {31'd0, out_stb}, 0);
        for (int k = 0; k < 3; k++) begin
            out_ack = 1'b1;
            out_dat_s = 32'hB00 + 32'(k);
            #1;
            chk("d_ack_blocked", {28'd0, in_ack}, 0);
            chk("d_drain_cyc", {31'd0, out_cyc}, 1);
            tick();
        end
        out_ack = 1'b0;
        #1;
        chk("d_idle_busy", {31'd0, busy}, 0);
        chk("d_idle_cyc", {31'd0, out_cyc}, 0);
        tick();
        #1;
        chk("d_next_grant", {30'd0, grant}, 0);
        chk("d_next_busy", {31'd0, busy}, 1);
        in_cyc = '0;
        tick();
        tick();

        // Watchdog on port 2
        in_cyc = 4'b0100;
        tick();
        #1;
        chk("e_grant", {30'd0, grant}, 2);
        in_stb[2] = 1'b1;
        in_adr[64 +: 32] = 32'h500;
        adr_q.push_back(32'h500);
        tick();
        in_stb[2] = 1'b0;
        seen = 1'b0;
        for (int k = 1; k <= 24 && !seen; k++) begin
            tick();
            #1;
            if (tmo) begin
                seen = 1'b1;
                chk("e_tmo_cycle", 32'(k), 16);
                chk("e_busy", {31'd0, busy}, 0);
                chk("e_cyc", {31'd0, out_cyc}, 0);
                chk("e_stall", {31'd0, in_stall[2]}, 1);
            end
        end
        chk("e_tmo_seen", {31'd0, seen}, 1);
        tick();
        #1;
        chk("e_pulse_end", {31'd0, tmo}, 0);
        chk("e_regrant", {30'd0, grant}, 2);
        in_cyc = '0;
        tick();
        tick();

        // Reset during OWN with two outstanding
        in_cyc = 4'b0010;
        tick();
        in_stb[1] = 1'b1;
        in_adr[32 +: 32] = 32'h600;
        adr_q.push_back(32'h600);
        tick();
        in_adr[32 +: 32] = 32'h604;
        adr_q.push_back(32'h604);
        tick();
        in_stb[1] = 1'b0;
        in_cyc = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("f_cyc", {31'd0, out_cyc}, 0);
        chk("f_grant", {30'd0, grant}, 0);
        chk("f_busy", {31'd0, busy}, 0);
        for (int k = 0; k < 2; k++) begin
            out_ack = 1'b1;
            out_dat_s = 32'hC00 + 32'(k);
            #1;
            chk("f_late_ack", {28'd0, in_ack}, 0);
            tick();
        end
        out_ack = 1'b0;
        in_cyc = 4'b0011;
        tick();
        #1;
        chk("f_first_grant", {30'd0, grant}, 0);
        chk("f_first_busy", {31'd0, busy}, 1);
        in_cyc = '0;
        tick();
        tick();

        chk("sb_adr_left", 32'(adr_q.size()), 0);
        chk("sb_ack_left", 32'(ack_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
Four-port round-robin arbiter that shares one pipelined Wishbone slave (cache0 or sdram path) between up to four bus masters, e.g. ins/dat buses from two CPUs or a DMA engine.
- Grants whole bus cycles: ownership is held while the granted master keeps cyc asserted.
- Tracks outstanding pipelined transfers, caps them, and drains them before handing off.
- Watchdog recovers the bus if a slave never acks.

Parameters:
MAXOUT, 4, maximum outstanding (strobed but not acked) transfers; range 1..15.
TIMEOUT, 1024, cycles with outstanding transfers and no ack before forced release; range 2..65535.

Ports:
clk_i  input  1  system clock
rst_i  input  1  reset, synchronous, active-high
in0  if_wb.slave  -  master port 0
in1  if_wb.slave  -  master port 1
in2  if_wb.slave  -  master port 2
in3  if_wb.slave  -  master port 3
out  if_wb.master  -  shared downstream bus
grant  output  2  index of current/last owner
busy  output  1  high in OWN or DRAIN
timeout  output  1  one-cycle pulse on watchdog expiry

Behaviour:
- Clocking and reset:
  - One clock, clk_i; rst_i is synchronous, active-high. State updates on the rising edge.
  - Reset forces: state=IDLE, rr pointer=3 (so in0 has first priority), outstanding count=0, watchdog=0, grant=0, busy=0, timeout=0.
  - Reset mid-transfer abandons all outstanding transfers; no ack is forwarded afterwards.
- States: IDLE, OWN, DRAIN (enum).
- IDLE:
  - out.cyc=0, out.stb=0, out.we=0, out.sel=0, out.adr=0, out.dat_m=0.
  - All inN.stall=1, inN.ack=0, inN.dat_s=0.
  - If any inN.cyc=1, pick the first requester searching pointer+1, pointer+2, ... (mod 4).
  - On the next edge: grant<=pick, state<=OWN. Arbitration latency is 1 cycle from cyc to first visible out.cyc.
- OWN (granted port g):
  - out.cyc = in[g].cyc.
  - out.adr/we/sel/dat_m = in[g] values.
  - out.stb = in[g].stb & !full, where full = (count==MAXOUT).
  - in[g].stall = out.stall | full.
  - in[g].ack = out.ack; in[g].dat_s = out.dat_s.
  - Non-granted ports: stall=1, ack=0, dat_s=0.
  - When in[g].cyc falls: if count==0 (after this cycle's update) go to IDLE; otherwise go to DRAIN.
  - pointer<=g on leaving OWN.
- DRAIN:
  - out.cyc=1, out.stb=0.
  - Acks are consumed and not forwarded: all ack=0.
  - Go to IDLE when count reaches 0.
- Outstanding counter (4 bits):
  - +1 on out.stb & !out.stall; -1 on out.ack.
  - Both in the same cycle: unchanged.
  - Ack while count==0: ignored, no underflow.
- Watchdog (16 bits):
  - Counts cycles in OWN/DRAIN with count>0 and no out.ack.
  - Clears on any ack or when count==0.
  - On reaching TIMEOUT:
    - timeout=1 for one cycle; count<=0; state<=IDLE; pointer<=g.
    - out.cyc is low from the next cycle.
    - Granted master still holding cyc is stalled in IDLE until re-granted normally.
- Handoff:
  - At least one IDLE cycle (out.cyc=0) always separates two owners.
  - The same port may be re-granted only if no other port requests (round-robin fairness).
- busy = (state!=IDLE). grant holds its value in IDLE.

Decomposition:
- Package wb_arb_pkg:
  - arb_state_t enum {IDLE, OWN, DRAIN}.
  - NPORTS=4, GRANT_W=2, CNT_W=4, WDOG_W=16.
- Sub-module rr_picker (combinational):
  - Inputs: 4-bit request vector, 2-bit pointer.
  - Outputs: valid, 2-bit pick.
- Top level holds the FSM, counters and the mux/demux.

Test Plan:
- Reset then in2.cyc=stb=1, adr=0x100, single read with ack after 2 cycles -> out.cyc rises 1 cycle after request; in2.ack with dat_s=0xDEADBEEF; grant=2; IDLE after cyc drop.
- in0..in3 all hold cyc, each does 1 transfer then drops -> grant order 0,1,2,3,0; one out.cyc=0 cycle between owners.
- in1 issues 6 back-to-back strobes, slave stall=0, ack delayed 8 cycles, MAXOUT=4 -> exactly 4 out.stb accepted, in1.stall=1 until first ack, then the remaining 2 pass.
- in3 strobes 3, drops cyc before acks -> DRAIN, out.cyc stays 1, 3 acks absorbed with in3.ack=0, then IDLE; in0 waiting is granted next.
- TIMEOUT=16, slave never acks one strobe -> timeout pulse at cycle 16 after last activity, count=0, out.cyc=0 next cycle, busy=0.
- rst_i asserted during OWN with count=2 -> next cycle out.cyc=0, grant=0, busy=0; late acks not forwarded; first request afterwards from in0 and in1 grants in0.
